// File: rtl/multi_src_restart_timer_pkg.sv
// Shared types and helpers for the multi-source restart timer.
// Holds the state encoding, default-derivation constants and a constant clog2.
package multi_src_restart_timer_pkg;

   typedef enum logic {
      ST_HOLD     = 1'b0,
      ST_RELEASED = 1'b1
   } state_e;

   localparam int DEF_CLOCK_MHZ = 27;
   localparam int DEF_HOLD_SECS = 5;

   // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
   function automatic integer clog2(input integer value);
      integer res;
      begin
         res = 0;
         for (integer i = 0; i < 31; i = i + 1)
            if ((32'sd1 <<< i) < value) res = i + 1;
         clog2 = res;
      end
   endfunction

endpackage

// File: rtl/multi_src_restart_timer_tick_prescaler.sv
// Free-running 0..TICK_CYCLES-1 prescaler that flags its terminal count.
// clr has priority over en; the counter holds when en is low.
module tick_prescaler
   import multi_src_restart_timer_pkg::*;
#(
   parameter int TICK_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PW = clog2(TICK_CYCLES);
   localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)       cnt_d = '0;
      else if (tick) cnt_d = '0;
      else if (en)   cnt_d = cnt_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multi_src_restart_timer.sv
// Holds reconfig high until all unmasked activity sources have been quiet
// for HOLD_TICKS prescaler ticks; supports forced release and optional re-arm.
module multi_src_restart_timer
   import multi_src_restart_timer_pkg::*;
#(
   parameter int CLOCK_MHZ   = DEF_CLOCK_MHZ,
   parameter int HOLD_SECS   = DEF_HOLD_SECS,
   parameter int TICK_CYCLES = CLOCK_MHZ * 1000,
   parameter int HOLD_TICKS  = HOLD_SECS * 1000,
   parameter int NUM_SRC     = 2,
   parameter int SYNC_STAGES = 2,
   parameter int REARM_EN    = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_SRC-1:0]              activity_n,
   input  logic [NUM_SRC-1:0]              src_mask,
   input  logic                            force_release,
   input  logic                            rearm,
   output logic                            reconfig,
   output logic [clog2(HOLD_TICKS+1)-1:0]  remaining_ticks,
   output logic [NUM_SRC-1:0]              activity_seen,
   output logic                            state_o
);

   localparam int CW = clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_TICKS);
   localparam logic [CW-1:0] LAST_TICK = CW'(HOLD_TICKS - 1);

   logic [NUM_SRC-1:0] sync_n;

   // Synchroniser flops reset to 1 so a source reads inactive out of reset.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      always_comb sync_d = {sync_q[SYNC_STAGES-2:0], activity_n[i]};
      always_ff @(posedge clk) begin
         if (!rst_n) sync_q <= '1;
         else        sync_q <= sync_d;
      end
      assign sync_n[i] = sync_q[SYNC_STAGES-1];
   end

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d, rem_q, rem_d;
   logic [NUM_SRC-1:0] seen_q, seen_d;
   logic               act_any, tick, pre_clr, pre_en;

   assign act_any = |(~sync_n & ~src_mask);
   assign pre_en  = (state_q == ST_HOLD);
   assign pre_clr = act_any || force_release || (state_q == ST_RELEASED);

   tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (pre_clr),
      .en    (pre_en),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seen_d  = seen_q | ~sync_n;
      case (state_q)
         ST_HOLD: begin
            if (force_release) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else if (act_any) begin
               cnt_d = '0;
            end else if (tick) begin
               if (cnt_q == LAST_TICK) begin
                  state_d = ST_RELEASED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_RELEASED: begin
            if ((REARM_EN != 0) && rearm) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_HOLD;
      endcase
      // Status is computed from next-state values so it lands with the counter.
      rem_d = (state_d == ST_RELEASED) ? '0 : (HOLD_MAX - cnt_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         rem_q   <= HOLD_MAX;
         seen_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         seen_q  <= seen_d;
      end
   end

   assign reconfig        = (state_q == ST_HOLD);
   assign state_o         = state_q;
   assign remaining_ticks = rem_q;
   assign activity_seen   = seen_q;

endmodule

// File: doc/multi_src_restart_timer.md
Name: multi_src_restart_timer

Overview:
- Parametrised successor to the single-channel power-up reconfiguration hold timer.
- Holds `reconfig` high after reset. Drops it low once none of NUM_SRC activity inputs has been active for a programmable hold time.
- Adds per-source masking, a forced release, an optional re-arm, and status outputs.
- Sits between the ESP/host chip-select lines and the FPGA reconfiguration pin.

Parameters:
- CLOCK_MHZ, 27: input clock in MHz; used only for defaults.
- HOLD_SECS, 5: hold time in seconds; used only for defaults.
- TICK_CYCLES, CLOCK_MHZ*1000: clocks per 1 ms tick. Overridable for simulation; must be ≥2.
- HOLD_TICKS, HOLD_SECS*1000: ticks of inactivity before release. Must be ≥1.
- NUM_SRC, 2: number of active-low activity inputs.
- SYNC_STAGES, 2: synchroniser depth per activity input. Must be ≥2.
- REARM_EN, 1: 1 means `rearm` is honoured; 0 means RELEASED is terminal until reset.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous, active-low reset.
- activity_n, input, NUM_SRC: asynchronous active-low activity lines (e.g. `esp_cs_n`).
- src_mask, input, NUM_SRC: 1 = source ignored. Synchronous to `clk`.
- force_release, input, 1: single-cycle pulse; release immediately.
- rearm, input, 1: single-cycle pulse; return to HOLD from RELEASED.
- reconfig, output, 1: high = hold FPGA in reconfiguration window.
- remaining_ticks, output, clog2(HOLD_TICKS+1): ticks left before release.
- activity_seen, output, NUM_SRC: sticky per-source activity flags.
- state_o, output, 1: 0 = HOLD, 1 = RELEASED.

Behaviour:

Clock and reset
- One clock, `clk`. Reset is synchronous and active-low on `rst_n`, sampled at the rising edge of `clk`.
- Reset values:
  - reconfig = 1, state = HOLD.
  - Prescaler = 0, tick counter = 0, remaining_ticks = HOLD_TICKS.
  - activity_seen = 0.
  - All synchroniser flops = 1 (inactive).
- Reset mid-operation (either state) returns to the above on the next edge.

Activity detection
- Each `activity_n[i]` passes through SYNC_STAGES flops.
- act_any = OR over i of (~sync[i] & ~src_mask[i]).
- Latency from an input edge to its effect on the counters is SYNC_STAGES+1 clocks.
- `activity_seen[i]` is set when sync[i] is low, regardless of mask. It clears only on reset.

State HOLD
- If force_release: next state = RELEASED, reconfig = 0 next edge. This has highest priority, including over act_any.
- Else if act_any: prescaler = 0, tick counter = 0.
- Else the prescaler counts 0..TICK_CYCLES-1 and wraps. The tick is asserted on the cycle prescaler == TICK_CYCLES-1.
- On a tick: if tick counter == HOLD_TICKS-1, go to RELEASED and set reconfig = 0. Otherwise increment the tick counter.
- If act_any and the expiry tick fall in the same cycle, act_any wins: counters clear and the block stays in HOLD.
- With no activity from the first post-reset edge, reconfig is low after exactly TICK_CYCLES*HOLD_TICKS edges.

State RELEASED
- reconfig stays 0. Activity is ignored for the counters but still updates activity_seen.
- If rearm and REARM_EN = 1: go to HOLD with reconfig = 1, prescaler = 0, tick counter = 0.
- If REARM_EN = 0, rearm is ignored.
- force_release in RELEASED has no effect.

Status outputs
- remaining_ticks = HOLD_TICKS minus the tick counter in HOLD, and 0 in RELEASED.
- Registered with the counter, so no extra latency.

Width and arithmetic rules
- Prescaler width = clog2(TICK_CYCLES); tick counter width = clog2(HOLD_TICKS+1). Use a Verilog-2001 clog2 function.
- Counters never exceed their terminal value; no overflow or wrap-around beyond terminal.

Decomposition:
- Shared package/header: the clog2 function, the state encodings HOLD = 1'b0 and RELEASED = 1'b1, and the default-derivation constants.
- One sub-module, `tick_prescaler`, is natural:
  - Inputs: clk, rst_n, clr, en.
  - Output: tick.
  - Parameter: TICK_CYCLES.
- The synchroniser is an inline generate loop. Everything else stays in the top-level block.

Test Plan (TICK_CYCLES=4, HOLD_TICKS=10, NUM_SRC=2, SYNC_STAGES=2):
1. Release rst_n with all activity_n = 1 → reconfig stays 1 for 39 edges, then is 0 after edge 40; remaining_ticks steps 10→0.
2. Pulse activity_n[0] low for 1 cycle at edge 30 → counters clear 3 edges later; reconfig falls 40 edges after the clear; activity_seen = 2'b01.
3. src_mask = 2'b10 with activity_n[1] held low → timer expires at edge 40 as in scenario 1; activity_seen[1] = 1.
4. force_release at edge 5 while activity_n[0] is low → reconfig = 0 at edge 6; state_o = 1.
5. In RELEASED, pulse rearm → reconfig = 1 next edge, remaining_ticks = 10, re-expires after 40 edges. Repeat with REARM_EN = 0 → reconfig stays 0.
6. Assert rst_n low for 1 cycle mid-HOLD (edge 20) and mid-RELEASED → all outputs return to reset values next edge; activity landing on the expiry-tick cycle → remains in HOLD.
